// File: rtl/fifo_push_arbiter_if.sv
// Producer/FIFO-write-port bundle for fifo_push_arbiter; slave = arbiter side, master = producers+FIFO.
// FIFO_ARB_STATS_EN adds the beat_total / stall_cycles statistics signals.
interface fifo_push_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               fifo_push;
  logic [DATA_WIDTH-1:0]              fifo_wr_data;
  logic                               fifo_full;
  logic [ID_WIDTH-1:0]                grant_id;
  logic                               busy;

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0]           beat_total;
  logic [31:0]                        stall_cycles;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_push, fifo_wr_data, grant_id, busy, beat_total, stall_cycles
  );
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_push, fifo_wr_data, grant_id, busy, beat_total, stall_cycles
  );
`else
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_push, fifo_wr_data, grant_id, busy
  );
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_push, fifo_wr_data, grant_id, busy
  );
`endif
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat and stall statistics under FIFO_ARB_STATS_EN.
module fifo_push_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic               clk,
  input  logic               reset,
  fifo_push_arbiter_if.slave bus
);
  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [ID_WIDTH-1:0]  grant_q, grant_nxt;
  logic [ID_WIDTH-1:0]  last_grant, last_grant_nxt;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
  logic [ID_WIDTH-1:0]  cand, pick;
  logic                 pick_found;
  logic                 beat;

  // Round-robin search starting just after the previous owner, wrapping at NUM_REQ.
  always_comb begin
    cand       = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((32'(last_grant) + i) % NUM_REQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant_q;
    last_grant_nxt   = last_grant;
    beat_cnt_nxt     = beat_cnt;
    beat             = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_push    = 1'b0;
    bus.fifo_wr_data = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt    = pick;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        // Zero-latency forward of the owner's beat; full stalls everything.
        bus.req_ready[grant_q] = ~bus.fifo_full;
        beat                   = bus.req_valid[grant_q] & ~bus.fifo_full;
        bus.fifo_push          = beat;
        bus.fifo_wr_data       = bus.req_data[grant_q];
        if (beat) begin
          beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
          if (bus.req_last[grant_q] || (beat_cnt_nxt == CNT_MAX)) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_q;
            beat_cnt_nxt   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= LAST_ID;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state == BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] beat_total;
  logic [31:0]              stall_cycles;

  // Saturating counters of pushed beats per owner and of full-stalled owner beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_total   <= '0;
      stall_cycles <= '0;
    end else begin
      if (beat && (beat_total[grant_q] != '1)) begin
        beat_total[grant_q] <= beat_total[grant_q] + 32'd1;
      end
      if ((state == BURST) && bus.req_valid[grant_q] && bus.fifo_full && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

  assign bus.beat_total   = beat_total;
  assign bus.stall_cycles = stall_cycles;
`endif
endmodule
